nic_vc_allocator: RTL and testbench

- NIC-side virtual-channel allocator. Matches output buffers holding a packet head to free VC pointers of the requested virtual network (VN).
- Drives the pointer-grant inputs of fifo_nic2noc (g_fifo_pointer_i, g_fifo_out_buffer_id_i) and consumes its fifo_pointer_state_o.
- Issues at most one grant per cycle, with round-robin fairness over buffers and over VCs within each VN.

---
 rtl/nic_vc_allocator_pkg.sv | 24 ++
 rtl/nic_vc_allocator_rr_arbiter.sv | 34 +++
 rtl/nic_vc_allocator.sv | 166 ++++++++++++++++
 tb/tb_nic_vc_allocator.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/nic_vc_allocator_pkg.sv
// nic_vc_allocator_pkg
// Shared NIC sizing constants and a clog2 helper for the VC allocator.
// N_TOT_OF_VC pointers are indexed vn*N_OF_VC + vc.
package nic_vc_allocator_pkg;

    localparam int N_OF_VC           = 2;
    localparam int N_OF_VN           = 3;
    localparam int N_TOT_OF_VC       = N_OF_VC * N_OF_VN;
    localparam int N_FIFO_OUT_BUFFER = 8;
    localparam int FLIT_WIDTH        = 32;

    // Ceiling log2, never below 1 so single-entry fields still get a bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    localparam int N_BITS_POINTER = clog2(N_FIFO_OUT_BUFFER);
    localparam int N_BITS_VN      = clog2(N_OF_VN);
    localparam int VC_PTR_W       = clog2(N_OF_VC);

endpackage

// File: rtl/nic_vc_allocator_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin picker: grants the first set request at or
// after ptr_i, wrapping modulo N.
//   req_i  [N]   request vector
//   ptr_i  [PW]  highest-priority index
//   gnt_o  [N]   one-hot-or-zero grant
//   vld_o        any request granted
module rr_arbiter
    import nic_vc_allocator_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          vld_o
);

    always_comb begin
        int idx;
        gnt_o = '0;
        vld_o = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!vld_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                vld_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nic_vc_allocator.sv
// nic_vc_allocator
// NIC-side VC allocator: matches output buffers holding a packet head to a
// free VC pointer of the requested VN, at most one grant per cycle, with
// round-robin fairness over buffers and over VCs inside each VN.
// Ports:
//   clk, rst                async active-high reset
//   req_i                   per-buffer head-pending request (level)
//   req_vn_i                per-buffer requested VN, N_BITS_VN each
//   fifo_pointer_state_i    1 = VC pointer free
//   g_fifo_pointer_o        registered one-hot-or-zero VC grant
//   g_fifo_out_buffer_id_o  buffer id in the granted VC's slice
//   grant_o                 registered one-hot-or-zero buffer grant
//   invalid_vn_o            registered flag: a requester carries VN >= N_OF_VN
// Optional (macro VC_ALLOC_STATS_EN): grant_count_o, starve_count_o
// saturating 16-bit counters.
module nic_vc_allocator
    import nic_vc_allocator_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_FIFO_OUT_BUFFER-1:0]          req_i,
    input  logic [N_FIFO_OUT_BUFFER*N_BITS_VN-1:0] req_vn_i,
    input  logic [N_TOT_OF_VC-1:0]                fifo_pointer_state_i,
    output logic [N_TOT_OF_VC-1:0]                g_fifo_pointer_o,
    output logic [N_TOT_OF_VC*N_BITS_POINTER-1:0] g_fifo_out_buffer_id_o,
    output logic [N_FIFO_OUT_BUFFER-1:0]          grant_o,
    output logic                                  invalid_vn_o
`ifdef VC_ALLOC_STATS_EN
    ,
    output logic [15:0]                           grant_count_o,
    output logic [15:0]                           starve_count_o
`endif
);

    logic [N_FIFO_OUT_BUFFER-1:0][N_BITS_VN-1:0] req_vn;
    logic [N_OF_VN-1:0][N_OF_VC-1:0]             vc_free, vc_gnt;
    logic [N_OF_VN-1:0]                          vc_vld;
    logic [N_OF_VN-1:0][VC_PTR_W-1:0]            rr_vc_q, rr_vc_d;
    logic [N_TOT_OF_VC-1:0]                      vc_res_q, vc_res_d;
    logic [N_FIFO_OUT_BUFFER-1:0]                buf_res_q, buf_res_d;
    logic [N_FIFO_OUT_BUFFER-1:0]                buf_elig, buf_gnt, vn_ok;
    logic                                        buf_vld;
    logic [N_BITS_POINTER-1:0]                   rr_buf_q, rr_buf_d;

    logic [N_TOT_OF_VC-1:0]                      g_ptr_q, g_ptr_d;
    logic [N_TOT_OF_VC-1:0][N_BITS_POINTER-1:0]  id_q, id_d;
    logic [N_FIFO_OUT_BUFFER-1:0]                grant_q, grant_d;
    logic                                        invalid_q, invalid_d;

    assign req_vn = req_vn_i;

    // Per-VN VC arbitration; a pointer is usable only if free and not
    // already promised to a buffer whose grant fifo_nic2noc hasn't absorbed.
    for (genvar vn = 0; vn < N_OF_VN; vn++) begin : g_vn
        assign vc_free[vn] = fifo_pointer_state_i[vn*N_OF_VC +: N_OF_VC]
                           & ~vc_res_q[vn*N_OF_VC +: N_OF_VC];
        rr_arbiter #(.N(N_OF_VC), .PW(VC_PTR_W)) u_vc_arb (
            .req_i (vc_free[vn]),
            .ptr_i (rr_vc_q[vn]),
            .gnt_o (vc_gnt[vn]),
            .vld_o (vc_vld[vn])
        );
    end

    // A buffer whose VN has nothing available is simply not eligible, so the
    // buffer arbiter skips it instead of stalling.
    always_comb begin
        buf_elig = '0;
        vn_ok    = '0;
        for (int b = 0; b < N_FIFO_OUT_BUFFER; b++) begin
            vn_ok[b] = (int'(req_vn[b]) < N_OF_VN);
            for (int v = 0; v < N_OF_VN; v++)
                if (req_vn[b] == N_BITS_VN'(v) && req_i[b] && !buf_res_q[b] && vc_vld[v])
                    buf_elig[b] = 1'b1;
        end
    end

    rr_arbiter #(.N(N_FIFO_OUT_BUFFER), .PW(N_BITS_POINTER)) u_buf_arb (
        .req_i (buf_elig),
        .ptr_i (rr_buf_q),
        .gnt_o (buf_gnt),
        .vld_o (buf_vld)
    );

    always_comb begin
        g_ptr_d  = '0;
        id_d     = '0;
        grant_d  = '0;
        rr_buf_d = rr_buf_q;
        rr_vc_d  = rr_vc_q;
        if (buf_vld) begin
            grant_d = buf_gnt;
            for (int b = 0; b < N_FIFO_OUT_BUFFER; b++) begin
                if (buf_gnt[b]) begin
                    rr_buf_d = N_BITS_POINTER'((b + 1) % N_FIFO_OUT_BUFFER);
                    for (int v = 0; v < N_OF_VN; v++) begin
                        if (req_vn[b] == N_BITS_VN'(v)) begin
                            for (int c = 0; c < N_OF_VC; c++) begin
                                if (vc_gnt[v][c]) begin
                                    g_ptr_d[v*N_OF_VC + c] = 1'b1;
                                    id_d[v*N_OF_VC + c]    = N_BITS_POINTER'(b);
                                    rr_vc_d[v]             = VC_PTR_W'((c + 1) % N_OF_VC);
                                end
                            end
                        end
                    end
                end
            end
        end
        // Clear on pointer taken / request dropped; a same-cycle set wins.
        vc_res_d  = (vc_res_q & fifo_pointer_state_i) | g_ptr_d;
        buf_res_d = (buf_res_q & req_i) | grant_d;
        invalid_d = |(req_i & ~vn_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_ptr_q   <= '0;
            id_q      <= '0;
            grant_q   <= '0;
            invalid_q <= 1'b0;
            rr_buf_q  <= '0;
            rr_vc_q   <= '0;
            vc_res_q  <= '0;
            buf_res_q <= '0;
        end else begin
            g_ptr_q   <= g_ptr_d;
            id_q      <= id_d;
            grant_q   <= grant_d;
            invalid_q <= invalid_d;
            rr_buf_q  <= rr_buf_d;
            rr_vc_q   <= rr_vc_d;
            vc_res_q  <= vc_res_d;
            buf_res_q <= buf_res_d;
        end
    end

    assign g_fifo_pointer_o       = g_ptr_q;
    assign g_fifo_out_buffer_id_o = id_q;
    assign grant_o                = grant_q;
    assign invalid_vn_o           = invalid_q;

`ifdef VC_ALLOC_STATS_EN
    logic [15:0] grant_cnt_q, starve_cnt_q;
    logic        pending;

    // Pending = a valid-VN head still waiting for its first grant.
    assign pending = |(req_i & ~buf_res_q & vn_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt_q  <= '0;
            starve_cnt_q <= '0;
        end else begin
            if (buf_vld && grant_cnt_q != 16'hFFFF)
                grant_cnt_q <= grant_cnt_q + 16'd1;
            if (pending && !buf_vld && starve_cnt_q != 16'hFFFF)
                starve_cnt_q <= starve_cnt_q + 16'd1;
        end
    end

    assign grant_count_o  = grant_cnt_q;
    assign starve_count_o = starve_cnt_q;
`endif

endmodule

// File: tb/tb_nic_vc_allocator.sv
// tb_nic_vc_allocator
// Directed vectors with hand-computed expectations for nic_vc_allocator.
// Inputs change 1ns after a rising edge; outputs are checked 1ns after the
// edge that sampled them.
module tb_nic_vc_allocator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  req_i = '0;
    logic [15:0] req_vn_i = '0;
    logic [5:0]  state_i = '0;
    logic [5:0]  g_ptr_o;
    logic [17:0] id_o;
    logic [7:0]  grant_o;
    logic        invalid_vn_o;
`ifdef VC_ALLOC_STATS_EN
    logic [15:0] grant_count_o, starve_count_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nic_vc_allocator dut (
        .clk                    (clk),
        .rst                    (rst),
        .req_i                  (req_i),
        .req_vn_i               (req_vn_i),
        .fifo_pointer_state_i   (state_i),
        .g_fifo_pointer_o       (g_ptr_o),
        .g_fifo_out_buffer_id_o (id_o),
        .grant_o                (grant_o),
        .invalid_vn_o           (invalid_vn_o)
`ifdef VC_ALLOC_STATS_EN
        ,
        .grant_count_o          (grant_count_o),
        .starve_count_o         (starve_count_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] g, input logic [5:0] p,
                           input logic [17:0] id);
        chk({tag, ".grant"}, 32'(grant_o), 32'(g));
        chk({tag, ".ptr"},   32'(g_ptr_o), 32'(p));
        chk({tag, ".id"},    32'(id_o),    32'(id));
    endtask

    task automatic do_reset();
        req_i = '0; req_vn_i = '0; state_i = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        tick();
        chk_out("rst", 8'h00, 6'h00, 18'h0);
        chk("rst.inv", 32'(invalid_vn_o), 32'h0);
        rst = 1'b0;

        // Buffer0 -> VN1 gets VC2 (index 1*2+0); no re-grant while held
        req_i = 8'b0000_0001; req_vn_i = 16'h0001; state_i = 6'b111111;
        tick();
        chk_out("s1.g", 8'b0000_0001, 6'b000100, 18'h0);
        tick();
        chk_out("s1.hold1", 8'h00, 6'h00, 18'h0);
        tick();
        chk_out("s1.hold2", 8'h00, 6'h00, 18'h0);

        // Buffers 1,2 on VN0: VC0 then VC1 (VC0 still reserved)
        do_reset();
        req_i = 8'b0000_0110; req_vn_i = 16'h0000; state_i = 6'b111111;
        tick();
        chk_out("s2.t1", 8'b0000_0010, 6'b000001, 18'h1);
        tick();
        chk_out("s2.t2", 8'b0000_0100, 6'b000010, 18'h2 << 3);
        tick();
        chk_out("s2.t3", 8'h00, 6'h00, 18'h0);

        // VN2 full: buffer0 (VN2) skipped, buffer3 (VN1) granted VC2
        do_reset();
        req_i = 8'b0000_1001; req_vn_i = 16'h0042; state_i = 6'b001111;
        tick();
        chk_out("s3.t1", 8'b0000_1000, 6'b000100, 18'h3 << 6);
        tick();
        chk_out("s3.t2", 8'h00, 6'h00, 18'h0);

        // Buffers 0/1 alternate, VC0/VC1 alternate
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req_vn_i = 16'h0000;
            if (i == 0)          begin req_i = 8'b11; state_i = 6'b000011; end
            else if (i % 2 == 0) begin req_i = 8'b01; state_i = 6'b000001; end
            else                 begin req_i = 8'b10; state_i = 6'b000010; end
            tick();
            if (i % 2 == 0) chk_out($sformatf("s4.%0d", i), 8'b01, 6'b000001, 18'h0);
            else            chk_out($sformatf("s4.%0d", i), 8'b10, 6'b000010, 18'h1 << 3);
        end

        // Invalid VN on buffer0 alongside a valid buffer1
        do_reset();
        req_i = 8'b0000_0011; req_vn_i = 16'h0003; state_i = 6'b111111;
        tick();
        chk("s5.inv", 32'(invalid_vn_o), 32'h1);
        chk_out("s5.t1", 8'b0000_0010, 6'b000001, 18'h1);
        req_i = 8'b0000_0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("s5.nog%0d", i), 32'(grant_o), 32'h0);
        end
        req_i = 8'b0;
        tick();
        chk("s5.inv0", 32'(invalid_vn_o), 32'h0);

        // Reset mid-operation, then RR pointers restart at 0
        do_reset();
        req_i = 8'b0000_0010; req_vn_i = 16'h0000; state_i = 6'b111111;
        tick();
        chk_out("s6.pre", 8'b0000_0010, 6'b000001, 18'h1);
        rst = 1'b1;
        #1;
        chk_out("s6.async", 8'h00, 6'h00, 18'h0);
        tick();
        req_i = 8'b0000_0110;
        rst = 1'b0;
        tick();
        chk_out("s6.post", 8'b0000_0010, 6'b000001, 18'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
